xbar_nxm: RTL

Parametrised N-master × M-slave request/acknowledge crossbar, successor to the fixed 2×2 crossbar. Each slave port has its own round-robin arbiter, so independent master/slave pairs run concurrently. It adds two things: an explicit slave request strobe, and error responses for undecodable addresses and for slaves that do not answer in time. It sits between the bus masters (cores, DMA) and the memory/peripheral slaves.

---
 rtl/xbar_nxm.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/xbar_nxm.sv
// rtl/xbar_nxm.sv - N-master x M-slave request/acknowledge crossbar with per-slave round-robin arbitration
//
// Each slave port runs its own IDLE/BUSY/TOUT controller. Masters are routed to a slave
// by the top SW address bits. Undecodable addresses and slaves that stay busy too long
// are answered with an error acknowledge carrying ERR_DATA.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   master_req/cmd/addr/wdata  per-master request (cmd 0 = read, 1 = write), held until ack
//   master_rdata/ack/err       per-master completion pulse, read data, error qualifier
//   slave_req/cmd/addr/wdata   per-slave request forwarded from the granted master
//   slave_rdata/ack            per-slave read data and one-cycle completion
//   last_mas                   per-slave index of the last granted master
`timescale 1ns/1ps
module xbar_nxm #(
    parameter int          N_MASTERS = 2,
    parameter int          N_SLAVES  = 2,
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF,
    localparam int         SW        = (N_SLAVES > 2) ? $clog2(N_SLAVES) : 1,
    localparam int         LW        = $clog2(N_MASTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_MASTERS-1:0]      master_req,
    input  logic [N_MASTERS-1:0]      master_cmd,
    input  logic [N_MASTERS*AW-1:0]   master_addr,
    input  logic [N_MASTERS*DW-1:0]   master_wdata,
    output logic [N_MASTERS*DW-1:0]   master_rdata,
    output logic [N_MASTERS-1:0]      master_ack,
    output logic [N_MASTERS-1:0]      master_err,
    output logic [N_SLAVES-1:0]       slave_req,
    output logic [N_SLAVES-1:0]       slave_cmd,
    output logic [N_SLAVES*AW-1:0]    slave_addr,
    output logic [N_SLAVES*DW-1:0]    slave_wdata,
    input  logic [N_SLAVES*DW-1:0]    slave_rdata,
    input  logic [N_SLAVES-1:0]       slave_ack,
    output logic [N_SLAVES*LW-1:0]    last_mas
);

    localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] ERR_W = DW'(ERR_DATA);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, TOUT = 2'd2} state_t;

    state_t          state_q [N_SLAVES];
    state_t          state_d [N_SLAVES];
    logic [LW-1:0]   grant_q [N_SLAVES];
    logic [LW-1:0]   grant_d [N_SLAVES];
    logic [LW-1:0]   last_q  [N_SLAVES];
    logic [LW-1:0]   last_d  [N_SLAVES];
    logic [CW-1:0]   cnt_q   [N_SLAVES];
    logic [CW-1:0]   cnt_d   [N_SLAVES];
    logic [N_MASTERS-1:0] dec_err_q;
    logic [N_MASTERS-1:0] dec_err_d;

    logic [SW-1:0]        target [N_MASTERS];
    logic [N_MASTERS-1:0] bad_addr;
    logic [N_MASTERS-1:0] held;
    logic                 found;

    // Address decode and "already owned by some slave" flags
    always_comb begin
        held = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            target[m]   = master_addr[m*AW + AW - SW +: SW];
            bad_addr[m] = int'(target[m]) >= N_SLAVES;
            for (int s = 0; s < N_SLAVES; s++) begin
                if (state_q[s] != IDLE && grant_q[s] == LW'(m)) begin
                    held[m] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < N_SLAVES; s++) begin
                state_q[s] <= IDLE;
                grant_q[s] <= '0;
                last_q[s]  <= LW'(N_MASTERS - 1);
                cnt_q[s]   <= '0;
            end
            dec_err_q <= '0;
        end else begin
            for (int s = 0; s < N_SLAVES; s++) begin
                state_q[s] <= state_d[s];
                grant_q[s] <= grant_d[s];
                last_q[s]  <= last_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            dec_err_q <= dec_err_d;
        end
    end

    always_comb begin
        found = 1'b0;
        for (int s = 0; s < N_SLAVES; s++) begin
            state_d[s] = state_q[s];
            grant_d[s] = grant_q[s];
            last_d[s]  = last_q[s];
            cnt_d[s]   = cnt_q[s];
            unique case (state_q[s])
                IDLE: begin
                    // Rotating search starting one past the last winner
                    found = 1'b0;
                    for (int k = 1; k <= N_MASTERS; k++) begin
                        for (int m = 0; m < N_MASTERS; m++) begin
                            if (!found && m == (int'(last_q[s]) + k) % N_MASTERS &&
                                master_req[m] && !bad_addr[m] &&
                                int'(target[m]) == s && !held[m]) begin
                                found      = 1'b1;
                                grant_d[s] = LW'(m);
                                last_d[s]  = LW'(m);
                                state_d[s] = BUSY;
                                cnt_d[s]   = '0;
                            end
                        end
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still wins over the timeout
                    if (slave_ack[s]) begin
                        state_d[s] = IDLE;
                    end else begin
                        cnt_d[s] = cnt_q[s] + 1'b1;
                        if (TIMEOUT != 0 && cnt_q[s] == CW'(TIMEOUT - 1)) begin
                            state_d[s] = TOUT;
                        end
                    end
                end
                TOUT:    state_d[s] = IDLE;
                default: state_d[s] = IDLE;
            endcase
        end
        // One error pulse per request: the cycle after the pulse is masked
        dec_err_d = master_req & bad_addr & ~dec_err_q;
    end

    always_comb begin
        master_ack   = '0;
        master_err   = '0;
        master_rdata = '0;
        slave_req    = '0;
        slave_cmd    = '0;
        slave_addr   = '0;
        slave_wdata  = '0;
        last_mas     = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            last_mas[s*LW +: LW] = last_q[s];
            for (int m = 0; m < N_MASTERS; m++) begin
                if (grant_q[s] == LW'(m)) begin
                    if (state_q[s] == BUSY) begin
                        slave_req[s]              = 1'b1;
                        slave_cmd[s]              = master_cmd[m];
                        slave_addr[s*AW +: AW]    = master_addr[m*AW +: AW];
                        slave_wdata[s*DW +: DW]   = master_wdata[m*DW +: DW];
                        if (slave_ack[s]) begin
                            master_ack[m]           = 1'b1;
                            master_rdata[m*DW +: DW] = slave_rdata[s*DW +: DW];
                        end
                    end else if (state_q[s] == TOUT) begin
                        master_ack[m]            = 1'b1;
                        master_err[m]            = 1'b1;
                        master_rdata[m*DW +: DW] = ERR_W;
                    end
                end
            end
        end
        for (int m = 0; m < N_MASTERS; m++) begin
            if (dec_err_q[m]) begin
                master_ack[m]            = 1'b1;
                master_err[m]            = 1'b1;
                master_rdata[m*DW +: DW] = ERR_W;
            end
        end
    end

endmodule
